ahb_slave_mux: RTL and testbench

// - Per-slave AHB bus stage directly downstream of the slave arbiter. It consumes hgrant, muxes the granted

---
 rtl/ahb_slave_mux.sv | 157 +++++++++++++++
 tb/tb_ahb_slave_mux.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_mux.sv
// Per-slave AHB stage: grant-driven address/control mux, data-phase owner tracking and burst-end (hlast) detection.
// Optional multi-hot grant check enabled by defining AHB_SLAVE_MUX_ONEHOT_CHK_EN (adds grant_err output).
module ahb_slave_mux #(
  parameter int MASTER_NUM = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           hclk,
  input  logic                           hreset,
  input  logic [MASTER_NUM-1:0]          hgrant,
  input  logic [MASTER_NUM-1:0]          hsel_m,
  input  logic [MASTER_NUM*ADDR_WIDTH-1:0] haddr_m,
  input  logic [MASTER_NUM*2-1:0]        htrans_m,
  input  logic [MASTER_NUM*3-1:0]        hburst_m,
  input  logic [MASTER_NUM-1:0]          hwrite_m,
  input  logic [MASTER_NUM*3-1:0]        hsize_m,
  input  logic [MASTER_NUM*DATA_WIDTH-1:0] hwdata_m,
  input  logic                           hready_s,
  input  logic                           hresp_s,
  input  logic [DATA_WIDTH-1:0]          hrdata_s,
  output logic                           hsel_s,
  output logic [ADDR_WIDTH-1:0]          haddr_s,
  output logic [1:0]                     htrans_s,
  output logic [2:0]                     hburst_s,
  output logic                           hwrite_s,
  output logic [2:0]                     hsize_s,
  output logic [DATA_WIDTH-1:0]          hwdata_s,
  output logic                           hready_m,
  output logic                           hresp_m,
  output logic [DATA_WIDTH-1:0]          hrdata_m,
  output logic                           hwait,
  output logic [MASTER_NUM-1:0]          hlast
`ifdef AHB_SLAVE_MUX_ONEHOT_CHK_EN
  ,
  output logic                           grant_err
`endif
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [2:0] BU_INCR   = 3'b001;

  typedef enum logic {D_IDLE, D_ACT} state_t;

  state_t                r_state, w_state_nxt;
  logic [MASTER_NUM-1:0] r_data_sel, w_data_sel_nxt;
  logic [3:0]            r_beat_cnt;
  logic                  w_accept;
  logic [3:0]            w_len;
  logic                  w_last_cond;

  function automatic logic [3:0] burst_len(input logic [2:0] burst);
    case (burst)
      3'b010, 3'b011: burst_len = 4'd3;
      3'b100, 3'b101: burst_len = 4'd7;
      3'b110, 3'b111: burst_len = 4'd15;
      default:        burst_len = 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] dec_sat(input logic [3:0] cnt);
    dec_sat = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
  endfunction

  // Address phase: AND-OR mux of master fields by grant
  always_comb begin
    haddr_s  = '0;
    htrans_s = TR_IDLE;
    hburst_s = '0;
    hwrite_s = 1'b0;
    hsize_s  = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (hgrant[i]) begin
        haddr_s  = haddr_s  | haddr_m[i*ADDR_WIDTH +: ADDR_WIDTH];
        htrans_s = htrans_s | htrans_m[i*2 +: 2];
        hburst_s = hburst_s | hburst_m[i*3 +: 3];
        hwrite_s = hwrite_s | hwrite_m[i];
        hsize_s  = hsize_s  | hsize_m[i*3 +: 3];
      end
    end
    hsel_s = |(hgrant & hsel_m);
`ifdef AHB_SLAVE_MUX_ONEHOT_CHK_EN
    // A multi-hot grant must never reach the slave as a live transfer
    if ($countones(hgrant) > 1) begin
      htrans_s = TR_IDLE;
      hsel_s   = 1'b0;
    end
`endif
  end

  assign hready_m = hready_s;
  assign hresp_m  = hresp_s;
  assign hrdata_m = hrdata_s;
  assign hwait    = ~hready_s;
  assign w_accept = hready_s & hsel_s & htrans_s[1];
  assign w_len    = burst_len(hburst_s);

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state    <= D_IDLE;
      r_data_sel <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_data_sel <= w_data_sel_nxt;
    end
  end

  // Owner is frozen through wait states, even if the grant moves on
  always_comb begin
    w_state_nxt    = r_state;
    w_data_sel_nxt = r_data_sel;
    if (hready_s) begin
      if (w_accept) begin
        w_state_nxt    = D_ACT;
        w_data_sel_nxt = hgrant;
      end else begin
        w_state_nxt    = D_IDLE;
        w_data_sel_nxt = '0;
      end
    end
  end

  // Data phase: write data from the registered owner
  always_comb begin
    hwdata_s = '0;
    if (r_state == D_ACT) begin
      for (int i = 0; i < MASTER_NUM; i++) begin
        if (r_data_sel[i]) hwdata_s = hwdata_s | hwdata_m[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_beat_cnt <= 4'd0;
    end else if (w_accept) begin
      if (htrans_s == TR_NONSEQ) r_beat_cnt <= w_len;
      else                       r_beat_cnt <= dec_sat(r_beat_cnt);
    end
  end

  // INCR terminated by IDLE signals the end of an undefined-length burst
  assign w_last_cond = hready_s & hsel_s &
                       (((htrans_s == TR_NONSEQ) && (w_len == 4'd0)) ||
                        ((htrans_s == TR_SEQ) && (r_beat_cnt == 4'd1)) ||
                        ((hburst_s == BU_INCR) && (htrans_s == TR_IDLE)));
  assign hlast = hgrant & {MASTER_NUM{w_last_cond}};

`ifdef AHB_SLAVE_MUX_ONEHOT_CHK_EN
  always_ff @(posedge hclk) begin
    if (hreset)                        grant_err <= 1'b0;
    else if ($countones(hgrant) > 1)   grant_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_ahb_slave_mux.sv
// Directed testbench for ahb_slave_mux (MASTER_NUM=2, 32-bit address/data).
module tb_ahb_slave_mux;
  localparam int MN = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            hclk = 1'b0;
  logic            hreset;
  logic [MN-1:0]   hgrant;
  logic [MN-1:0]   hsel_m;
  logic [MN*AW-1:0] haddr_m;
  logic [MN*2-1:0] htrans_m;
  logic [MN*3-1:0] hburst_m;
  logic [MN-1:0]   hwrite_m;
  logic [MN*3-1:0] hsize_m;
  logic [MN*DW-1:0] hwdata_m;
  logic            hready_s;
  logic            hresp_s;
  logic [DW-1:0]   hrdata_s;
  logic            hsel_s;
  logic [AW-1:0]   haddr_s;
  logic [1:0]      htrans_s;
  logic [2:0]      hburst_s;
  logic            hwrite_s;
  logic [2:0]      hsize_s;
  logic [DW-1:0]   hwdata_s;
  logic            hready_m;
  logic            hresp_m;
  logic [DW-1:0]   hrdata_m;
  logic            hwait;
  logic [MN-1:0]   hlast;
`ifdef AHB_SLAVE_MUX_ONEHOT_CHK_EN
  logic            grant_err;
`endif

  int total_cnt = 0;
  int fail_cnt  = 0;

  always #5 hclk = ~hclk;

  ahb_slave_mux #(.MASTER_NUM(MN), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .hclk(hclk), .hreset(hreset), .hgrant(hgrant), .hsel_m(hsel_m), .haddr_m(haddr_m),
    .htrans_m(htrans_m), .hburst_m(hburst_m), .hwrite_m(hwrite_m), .hsize_m(hsize_m),
    .hwdata_m(hwdata_m), .hready_s(hready_s), .hresp_s(hresp_s), .hrdata_s(hrdata_s),
    .hsel_s(hsel_s), .haddr_s(haddr_s), .htrans_s(htrans_s), .hburst_s(hburst_s),
    .hwrite_s(hwrite_s), .hsize_s(hsize_s), .hwdata_s(hwdata_s), .hready_m(hready_m),
    .hresp_m(hresp_m), .hrdata_m(hrdata_m), .hwait(hwait), .hlast(hlast)
`ifdef AHB_SLAVE_MUX_ONEHOT_CHK_EN
    , .grant_err(grant_err)
`endif
  );

  task automatic set_m(input int m, input logic sel, input logic [31:0] addr,
                       input logic [1:0] tr, input logic [2:0] bu, input logic [31:0] wd);
    hsel_m[m]             = sel;
    haddr_m[m*AW +: AW]   = addr;
    htrans_m[m*2 +: 2]    = tr;
    hburst_m[m*3 +: 3]    = bu;
    hwrite_m[m]           = 1'b1;
    hsize_m[m*3 +: 3]     = 3'b010;
    hwdata_m[m*DW +: DW]  = wd;
  endtask

  task automatic idle_all();
    hgrant = '0;
    set_m(0, 1'b0, 32'h0, 2'b00, 3'b000, 32'h0);
    set_m(1, 1'b0, 32'h0, 2'b00, 3'b000, 32'h0);
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic test_reset();
    hreset = 1'b1; hready_s = 1'b1; hresp_s = 1'b0; hrdata_s = 32'h0;
    idle_all();
    hgrant = 2'b01;
    set_m(0, 1'b1, 32'h0000_0040, 2'b00, 3'b000, 32'hAAAA_5555);
    for (int c = 0; c < 2; c++) begin
      tick();
      total_cnt++; if (hwdata_s !== 32'h0) begin fail_cnt++; $display("FAIL reset_hwdata got %h want %h", hwdata_s, 32'h0); end
      total_cnt++; if (hlast !== 2'b00) begin fail_cnt++; $display("FAIL reset_hlast got %b want %b", hlast, 2'b00); end
    end
    total_cnt++; if (dut.r_data_sel !== 2'b00) begin fail_cnt++; $display("FAIL reset_data_sel got %b want %b", dut.r_data_sel, 2'b00); end
    hreset = 1'b0;
    hready_s = 1'b0; #1;
    total_cnt++; if (hwait !== 1'b1) begin fail_cnt++; $display("FAIL reset_hwait_lo got %b want %b", hwait, 1'b1); end
    hready_s = 1'b1; hresp_s = 1'b1; hrdata_s = 32'hCAFE_F00D; #1;
    total_cnt++; if (hwait !== 1'b0) begin fail_cnt++; $display("FAIL reset_hwait_hi got %b want %b", hwait, 1'b0); end
    total_cnt++; if ({hready_m, hresp_m, hrdata_m} !== {1'b1, 1'b1, 32'hCAFE_F00D}) begin
      fail_cnt++; $display("FAIL bcast got %b%b_%h want 11_cafef00d", hready_m, hresp_m, hrdata_m); end
    hresp_s = 1'b0;
    idle_all();
    tick();
  endtask

  task automatic test_single_write();
    hgrant = 2'b01;
    set_m(0, 1'b1, 32'h0000_1000, 2'b10, 3'b000, 32'hDEAD_0001);
    #1;
    total_cnt++; if (haddr_s !== 32'h0000_1000) begin fail_cnt++; $display("FAIL single_haddr got %h want %h", haddr_s, 32'h1000); end
    total_cnt++; if ({hsel_s, htrans_s, hwrite_s, hsize_s} !== {1'b1, 2'b10, 1'b1, 3'b010}) begin
      fail_cnt++; $display("FAIL single_ctrl got %b want %b", {hsel_s, htrans_s, hwrite_s, hsize_s}, 7'b1101010); end
    total_cnt++; if (hlast !== 2'b01) begin fail_cnt++; $display("FAIL single_hlast got %b want %b", hlast, 2'b01); end
    tick();
    hgrant = 2'b00;
    set_m(0, 1'b0, 32'h0000_1000, 2'b00, 3'b000, 32'hDEAD_0001);
    #1;
    total_cnt++; if (hwdata_s !== 32'hDEAD_0001) begin fail_cnt++; $display("FAIL single_hwdata got %h want %h", hwdata_s, 32'hDEAD_0001); end
    total_cnt++; if ({hsel_s, htrans_s, haddr_s} !== 35'h0) begin
      fail_cnt++; $display("FAIL nogrant_addr got %b_%b_%h want 0_00_00000000", hsel_s, htrans_s, haddr_s); end
    tick();
    total_cnt++; if (hwdata_s !== 32'h0) begin fail_cnt++; $display("FAIL single_idle_hwdata got %h want %h", hwdata_s, 32'h0); end
  endtask

  task automatic test_incr4();
    logic [1:0] exp_last;
    logic [3:0] exp_cnt;
    hgrant = 2'b10;
    for (int b = 0; b < 4; b++) begin
      set_m(1, 1'b1, 32'h0000_2000 + 32'(b*4), (b == 0) ? 2'b10 : 2'b11, 3'b011, 32'hB000_0000 + 32'(b));
      #1;
      exp_last = (b == 3) ? 2'b10 : 2'b00;
      total_cnt++; if (hlast !== exp_last) begin fail_cnt++; $display("FAIL incr4_hlast beat %0d got %b want %b", b, hlast, exp_last); end
      tick();
      exp_cnt = 4'(3 - b);
      total_cnt++; if (dut.r_beat_cnt !== exp_cnt) begin fail_cnt++; $display("FAIL incr4_cnt beat %0d got %0d want %0d", b, dut.r_beat_cnt, exp_cnt); end
      total_cnt++; if (hwdata_s !== 32'hB000_0000 + 32'(b)) begin
        fail_cnt++; $display("FAIL incr4_hwdata beat %0d got %h want %h", b, hwdata_s, 32'hB000_0000 + 32'(b)); end
    end
    set_m(1, 1'b1, 32'h0000_2010, 2'b00, 3'b011, 32'h0);
    #1;
    total_cnt++; if (hlast !== 2'b00) begin fail_cnt++; $display("FAIL incr4_idle_hlast got %b want %b", hlast, 2'b00); end
    idle_all();
    tick();
  endtask

  task automatic test_incr_term();
    hgrant = 2'b01;
    set_m(0, 1'b1, 32'h0000_3000, 2'b00, 3'b001, 32'h0);
    #1;
    total_cnt++; if (hlast !== 2'b01) begin fail_cnt++; $display("FAIL incr_term_hlast got %b want %b", hlast, 2'b01); end
    hready_s = 1'b0; #1;
    total_cnt++; if (hlast !== 2'b00) begin fail_cnt++; $display("FAIL incr_term_wait_hlast got %b want %b", hlast, 2'b00); end
    hready_s = 1'b1;
    idle_all();
    tick();
  endtask

  task automatic test_wait_switch();
    hgrant = 2'b01;
    set_m(0, 1'b1, 32'h0000_4000, 2'b10, 3'b000, 32'h1111_0000);
    set_m(1, 1'b1, 32'h0000_5000, 2'b10, 3'b000, 32'h2222_0000);
    tick();
    hready_s = 1'b0;
    hgrant   = 2'b10;
    for (int c = 0; c < 3; c++) begin
      #1;
      total_cnt++; if (hwdata_s !== 32'h1111_0000) begin fail_cnt++; $display("FAIL wait_hwdata cyc %0d got %h want %h", c, hwdata_s, 32'h1111_0000); end
      total_cnt++; if ({hwait, hlast} !== 3'b100) begin fail_cnt++; $display("FAIL wait_hwait_hlast cyc %0d got %b want %b", c, {hwait, hlast}, 3'b100); end
      total_cnt++; if (haddr_s !== 32'h0000_5000) begin fail_cnt++; $display("FAIL wait_haddr cyc %0d got %h want %h", c, haddr_s, 32'h5000); end
      tick();
    end
    hready_s = 1'b1; #1;
    total_cnt++; if (hwdata_s !== 32'h1111_0000) begin fail_cnt++; $display("FAIL wait_release_hwdata got %h want %h", hwdata_s, 32'h1111_0000); end
    tick();
    total_cnt++; if (dut.r_data_sel !== 2'b10) begin fail_cnt++; $display("FAIL switch_data_sel got %b want %b", dut.r_data_sel, 2'b10); end
    total_cnt++; if (hwdata_s !== 32'h2222_0000) begin fail_cnt++; $display("FAIL switch_hwdata got %h want %h", hwdata_s, 32'h2222_0000); end
    idle_all();
    tick();
  endtask

  task automatic test_reset_mid_burst();
    hgrant = 2'b01;
    for (int b = 0; b < 3; b++) begin
      set_m(0, 1'b1, 32'h0000_6000 + 32'(b*4), (b == 0) ? 2'b10 : 2'b11, 3'b101, 32'h6000_0000 + 32'(b));
      tick();
    end
    total_cnt++; if (dut.r_beat_cnt !== 4'd5) begin fail_cnt++; $display("FAIL incr8_cnt got %0d want %0d", dut.r_beat_cnt, 5); end
    hreset = 1'b1;
    set_m(0, 1'b1, 32'h0000_600C, 2'b11, 3'b101, 32'h6000_0003);
    tick();
    hreset = 1'b0;
    total_cnt++; if (dut.r_beat_cnt !== 4'd0) begin fail_cnt++; $display("FAIL midrst_cnt got %0d want %0d", dut.r_beat_cnt, 0); end
    total_cnt++; if (hwdata_s !== 32'h0) begin fail_cnt++; $display("FAIL midrst_hwdata got %h want %h", hwdata_s, 32'h0); end
    total_cnt++; if (hlast !== 2'b00) begin fail_cnt++; $display("FAIL midrst_seq_hlast got %b want %b", hlast, 2'b00); end
    tick();
    total_cnt++; if (dut.r_beat_cnt !== 4'd0) begin fail_cnt++; $display("FAIL midrst_sat_cnt got %0d want %0d", dut.r_beat_cnt, 0); end
    idle_all();
    tick();
  endtask

  task automatic test_multi_hot();
    hgrant = 2'b11;
    set_m(0, 1'b1, 32'h0000_0F00, 2'b10, 3'b000, 32'h0);
    set_m(1, 1'b1, 32'h0000_00F0, 2'b10, 3'b000, 32'h0);
    #1;
`ifdef AHB_SLAVE_MUX_ONEHOT_CHK_EN
    total_cnt++; if ({hsel_s, htrans_s} !== 3'b000) begin fail_cnt++; $display("FAIL multihot_block got %b want %b", {hsel_s, htrans_s}, 3'b000); end
    tick();
    idle_all();
    #1;
    total_cnt++; if (grant_err !== 1'b1) begin fail_cnt++; $display("FAIL grant_err_set got %b want %b", grant_err, 1'b1); end
    tick(); tick();
    total_cnt++; if (grant_err !== 1'b1) begin fail_cnt++; $display("FAIL grant_err_sticky got %b want %b", grant_err, 1'b1); end
    hreset = 1'b1; tick(); hreset = 1'b0;
    total_cnt++; if (grant_err !== 1'b0) begin fail_cnt++; $display("FAIL grant_err_clr got %b want %b", grant_err, 1'b0); end
`else
    total_cnt++; if (haddr_s !== 32'h0000_0FF0) begin fail_cnt++; $display("FAIL multihot_or got %h want %h", haddr_s, 32'h0FF0); end
    idle_all();
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_incr4();
    test_incr_term();
    test_wait_switch();
    test_reset_mid_burst();
    test_multi_hot();
    $display("%0d/%0d checks passed", total_cnt - fail_cnt, total_cnt);
    $finish;
  end
endmodule
